// File: rtl/bep_frame_sync.sv
// bep_frame_sync: sync-word frame synchroniser for the decoded Manchester bit
// stream. Hunts for SYNC_WORD, then parses LEN, payload bytes and a CRC-8
// trailer (poly 0x07, init 0x00, MSB first). Payload bytes are forwarded as
// they complete; every frame attempt past sync ends with a frame_done status.
module bep_frame_sync #(
    parameter logic [7:0] SYNC_WORD = 8'hD5,
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_strobe,
    input  logic       bit_data,
    input  logic       abort,
    output logic [7:0] byte_data,
    output logic [7:0] byte_index,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [1:0] frame_err,
    output logic       in_frame
);

    localparam int TW = $clog2(TIMEOUT);

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CRC} state_t;

    state_t        state, state_nxt;
    logic [7:0]    sr, sr_nxt;
    logic [7:0]    crc, crc_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [7:0]    len, len_nxt;
    logic [2:0]    bitcnt, bitcnt_nxt;
    // Bits seen since (re)entering HUNT, saturating at 7: a sync match needs
    // a full window of bits that all arrived while hunting.
    logic [2:0]    hunt, hunt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic [7:0]    byte_data_nxt, byte_index_nxt;
    logic          byte_valid_nxt, frame_done_nxt, frame_ok_nxt;
    logic [1:0]    frame_err_nxt;

    logic [7:0]    sr_shift, crc_upd, cnt_inc;

    assign sr_shift = {sr[6:0], bit_data};
    assign crc_upd  = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_data) ? 8'h07 : 8'h00);
    assign cnt_inc  = cnt + 8'd1;

    // Next-state and next-output logic; priority abort > timeout > strobe.
    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        crc_nxt        = crc;
        cnt_nxt        = cnt;
        len_nxt        = len;
        bitcnt_nxt     = bitcnt;
        hunt_nxt       = hunt;
        tcnt_nxt       = tcnt;
        byte_data_nxt  = byte_data;
        byte_index_nxt = byte_index;
        byte_valid_nxt = 1'b0;
        frame_done_nxt = 1'b0;
        frame_ok_nxt   = frame_ok;
        frame_err_nxt  = frame_err;

        if (abort) begin
            // Silent return to HUNT; a coincident strobe is dropped.
            state_nxt  = ST_HUNT;
            sr_nxt     = 8'h00;
            crc_nxt    = 8'h00;
            cnt_nxt    = 8'h00;
            bitcnt_nxt = 3'd0;
            hunt_nxt   = 3'd0;
            tcnt_nxt   = '0;
        end else if (state != ST_HUNT && tcnt == TW'(TIMEOUT - 1) && !bit_strobe) begin
            state_nxt      = ST_HUNT;
            hunt_nxt       = 3'd0;
            tcnt_nxt       = '0;
            frame_done_nxt = 1'b1;
            frame_ok_nxt   = 1'b0;
            frame_err_nxt  = ERR_TIMEOUT;
        end else if (bit_strobe) begin
            sr_nxt   = sr_shift;
            tcnt_nxt = '0;
            if (state == ST_HUNT) begin
                if (hunt == 3'd7 && sr_shift == SYNC_WORD) begin
                    state_nxt  = ST_LEN;
                    bitcnt_nxt = 3'd0;
                    crc_nxt    = 8'h00;
                    cnt_nxt    = 8'h00;
                    hunt_nxt   = 3'd0;
                end else if (hunt != 3'd7) begin
                    hunt_nxt = hunt + 3'd1;
                end
            end else begin
                crc_nxt    = crc_upd;
                bitcnt_nxt = bitcnt + 3'd1;
                if (bitcnt == 3'd7) begin
                    case (state)
                        ST_LEN: begin
                            if (sr_shift == 8'h00) begin
                                state_nxt = ST_CRC;
                            end else if (sr_shift > 8'(MAX_LEN)) begin
                                state_nxt      = ST_HUNT;
                                hunt_nxt       = 3'd0;
                                frame_done_nxt = 1'b1;
                                frame_ok_nxt   = 1'b0;
                                frame_err_nxt  = ERR_LEN;
                            end else begin
                                len_nxt   = sr_shift;
                                state_nxt = ST_PAYLOAD;
                            end
                        end
                        ST_PAYLOAD: begin
                            byte_data_nxt  = sr_shift;
                            byte_index_nxt = cnt;
                            byte_valid_nxt = 1'b1;
                            cnt_nxt        = cnt_inc;
                            if (cnt_inc == len) begin
                                state_nxt = ST_CRC;
                            end
                        end
                        default: begin
                            // CRC trailer complete: residue over LEN..CRC must be zero.
                            state_nxt      = ST_HUNT;
                            hunt_nxt       = 3'd0;
                            frame_done_nxt = 1'b1;
                            frame_ok_nxt   = (crc_upd == 8'h00);
                            frame_err_nxt  = (crc_upd == 8'h00) ? ERR_NONE : ERR_CRC;
                        end
                    endcase
                end
            end
        end else if (state != ST_HUNT) begin
            tcnt_nxt = tcnt + TW'(1);
        end else begin
            tcnt_nxt = '0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            sr         <= 8'h00;
            crc        <= 8'h00;
            cnt        <= 8'h00;
            len        <= 8'h00;
            bitcnt     <= 3'd0;
            hunt       <= 3'd0;
            tcnt       <= '0;
            byte_data  <= 8'h00;
            byte_index <= 8'h00;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= ERR_NONE;
            in_frame   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            crc        <= crc_nxt;
            cnt        <= cnt_nxt;
            len        <= len_nxt;
            bitcnt     <= bitcnt_nxt;
            hunt       <= hunt_nxt;
            tcnt       <= tcnt_nxt;
            byte_data  <= byte_data_nxt;
            byte_index <= byte_index_nxt;
            byte_valid <= byte_valid_nxt;
            frame_done <= frame_done_nxt;
            frame_ok   <= frame_ok_nxt;
            frame_err  <= frame_err_nxt;
            in_frame   <= (state_nxt != ST_HUNT);
        end
    end

endmodule

// File: doc/bep_frame_sync.md
# bep_frame_sync

Frame synchroniser sitting directly downstream of the Manchester decode state machine, replacing edge-triggered start-of-transmission with sync-word framing. Consumes the decoded bit stream (one strobe per bit), hunts for a sync word, then parses a length byte, up to MAX_LEN payload bytes and a CRC-8 trailer. It emits each payload byte with its index and ends every frame with a status pulse. Its byte outputs feed the addressed parallel-output stage.

## Interface
Parameters:
- SYNC_WORD, 8'hD5: sync byte that starts a frame; matched MSB-first on a sliding 8-bit window.
- MAX_LEN, 16: largest legal LEN value (1..255).
- TIMEOUT, 1024: clock cycles without a bit strobe, inside a frame, before the frame is aborted (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- bit_strobe  in  1  single-cycle pulse; one decoded bit is valid on bit_data.
- bit_data  in  1  decoded bit value, sampled only when bit_strobe=1.
- abort  in  1  force return to HUNT (e.g. carrier loss); takes priority over everything except reset.
- byte_data  out  8  last completed payload byte.
- byte_index  out  8  index of byte_data within the payload, 0-based.
- byte_valid  out  1  one-cycle pulse; byte_data/byte_index are new.
- frame_done  out  1  one-cycle pulse at the end of every frame attempt past sync.
- frame_ok  out  1  with frame_done: 1 = CRC good, no error.
- frame_err  out  2  with frame_done: 0 none, 1 CRC, 2 length, 3 timeout.
- in_frame  out  1  1 in every state except HUNT.

## Operation
- Shift register sr[7:0]: on strobe, sr <= {sr[6:0], bit_data}. The bit counter bitcnt[2:0] counts bits within the current byte.
- States: HUNT, LEN, PAYLOAD, CRC.
- HUNT: on each strobe, compare {sr[6:0], bit_data} with SYNC_WORD. On a match, go to LEN, clear bitcnt, CRC := 8'h00, byte counter := 0. Partial matches never latch.
- LEN, PAYLOAD and CRC each consume 8 strobes per byte, MSB first. Every one of these bits also updates the CRC: crc <= {crc[6:0],1'b0} ^ ((crc[7]^bit) ? 8'h07 : 8'h00).
- LEN byte complete:
  - If the value is 0, go to CRC.
  - If the value exceeds MAX_LEN, pulse frame_done with frame_err=2, frame_ok=0, and go to HUNT.
  - Otherwise latch len and go to PAYLOAD.
- PAYLOAD byte complete: drive byte_data, byte_index (the counter), pulse byte_valid, and increment the counter. When counter+1 == len, go to CRC.
- CRC byte complete: the residue includes the CRC byte. A residue of 8'h00 gives frame_ok=1, frame_err=0; otherwise frame_ok=0, frame_err=1. Pulse frame_done and go to HUNT.
- Timeout counter: cleared on every strobe and in HUNT; otherwise increments each cycle. When it reaches TIMEOUT-1 with no strobe that cycle, pulse frame_done with frame_err=3 and go to HUNT.
- abort=1: go to HUNT and clear bitcnt, counters, CRC and sr. No frame_done pulse is issued. A strobe in the same cycle is discarded.
- Payload bytes are forwarded before the CRC check; the consumer must discard them if frame_ok=0.

## Timing
- Reset (rst_n=0 at a clk edge): state=HUNT, sr=0, crc=0, all counters 0. All outputs are 0: byte_data=0, byte_index=0, byte_valid=0, frame_done=0, frame_ok=0, frame_err=0, in_frame=0.
- All outputs are registered.
- byte_valid rises the cycle after the strobe carrying bit 0 of a payload byte.
- frame_done rises the cycle after the last CRC bit strobe, or the cycle after the LEN byte's last strobe for a length error.
- in_frame goes to 1 the cycle after the sync-completing strobe. It goes to 0 in the same cycle frame_done is asserted, or the cycle after abort.
- frame_ok and frame_err hold their values until the next frame_done. byte_data and byte_index hold until the next byte_valid.
- Back-to-back strobes (every cycle) are supported.
- A new sync word may start on the strobe immediately after the CRC byte. sr is not cleared at frame end, but a match requires 8 fresh bits in HUNT.
- Priority: rst_n > abort > timeout > strobe processing.

## Test plan
- Good frame: bits of D5 02 12 34 27 (MSB first, one strobe every 4 cycles) -> byte_valid with (0x12, idx 0), then (0x34, idx 1); frame_done with frame_ok=1, frame_err=0.
- Bad CRC: same frame with trailer 0x26 -> both bytes forwarded, then frame_done with frame_ok=0, frame_err=1.
- Length error: D5 11 with MAX_LEN=16 -> no byte_valid; frame_done with frame_err=2 one cycle after the LEN byte; in_frame=0.
- Zero length: D5 00 00 -> no byte_valid; frame_done with frame_ok=1.
- Timeout: TIMEOUT=16, D5 02 12 then silence -> exactly one byte_valid (0x12); frame_done with frame_err=3 sixteen cycles after the last strobe.
- Abort plus reset: abort held high together with a strobe mid-PAYLOAD -> in_frame=0 next cycle with no frame_done; a following clean good frame is decoded correctly. Separately, rst_n=0 mid-frame -> all outputs 0 on the next edge.
